// File: rtl/booth_mult_param.sv
// Sequential radix-2 Booth multiplier, signed or unsigned operands,
// loaded and unloaded over one WIDTH-bit bus.
module booth_mult_param #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    output logic             done,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 2);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        CALC,
        OUT_HI,
        OUT_LO
    } state_t;

    state_t state;
    state_t state_nx;

    logic               mode;
    logic [WIDTH:0]     m_reg;
    logic [WIDTH:0]     q_reg;
    logic [WIDTH+1:0]   a_reg;
    logic               q_m1;
    logic [CW-1:0]      cnt;

    logic [WIDTH:0]     ext_in;
    logic [WIDTH+1:0]   m_ext;
    logic [WIDTH+1:0]   a_sum;
    logic [2*WIDTH-1:0] prod;

    // Unsigned operands get a zero top bit so one signed datapath serves both
    assign ext_in = {mode & data_in[WIDTH-1], data_in};
    assign m_ext  = {m_reg[WIDTH], m_reg};
    assign prod   = {a_reg[WIDTH-2:0], q_reg};

    always_comb begin
        a_sum = a_reg;
        case ({q_reg[0], q_m1})
            2'b01:   a_sum = a_reg + m_ext;
            2'b10:   a_sum = a_reg - m_ext;
            default: a_sum = a_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = LOAD_A;
            LOAD_A:  state_nx = LOAD_B;
            LOAD_B:  state_nx = CALC;
            CALC:    if (cnt == CW'(1)) state_nx = OUT_HI;
            OUT_HI:  state_nx = OUT_LO;
            OUT_LO:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode  <= 1'b0;
            m_reg <= '0;
            q_reg <= '0;
            a_reg <= '0;
            q_m1  <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) mode <= signed_mode;
                end
                LOAD_A: begin
                    m_reg <= ext_in;
                end
                LOAD_B: begin
                    q_reg <= ext_in;
                    a_reg <= '0;
                    q_m1  <= 1'b0;
                    cnt   <= CW'(WIDTH + 1);
                end
                CALC: begin
                    a_reg <= {a_sum[WIDTH+1], a_sum[WIDTH+1:1]};
                    q_reg <= {a_sum[0], q_reg[WIDTH:1]};
                    q_m1  <= q_reg[0];
                    cnt   <= cnt - CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        data_out  = '0;
        out_valid = 1'b0;
        done      = 1'b0;
        busy      = (state != IDLE);
        case (state)
            OUT_HI: begin
                data_out  = prod[2*WIDTH-1:WIDTH];
                out_valid = 1'b1;
            end
            OUT_LO: begin
                data_out  = prod[WIDTH-1:0];
                out_valid = 1'b1;
                done      = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_booth_mult_param.sv
// Scoreboard bench for booth_mult_param at WIDTH=5 and WIDTH=8.
module tb_booth_mult_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       s5 = 1'b0, sm5 = 1'b0;
    logic [4:0] d5 = '0, o5;
    logic       v5, dn5, b5;

    logic       s8 = 1'b0, sm8 = 1'b0;
    logic [7:0] d8 = '0, o8;
    logic       v8, dn8, b8;

    int n_chk  = 0;
    int n_fail = 0;

    logic [5:0] q5[$];
    logic [8:0] q8[$];
    logic [5:0] e5;
    logic [8:0] e8;

    always #5 clk = ~clk;

    booth_mult_param #(.WIDTH(5)) dut5 (
        .clk(clk), .rst(rst), .start(s5), .signed_mode(sm5),
        .data_in(d5), .data_out(o5), .out_valid(v5),
        .done(dn5), .busy(b5)
    );

    booth_mult_param #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(s8), .signed_mode(sm8),
        .data_in(d8), .data_out(o8), .out_valid(v8),
        .done(dn8), .busy(b8)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Monitors: pop one expected {done, beat} per valid output
    always @(negedge clk) begin
        if (rst) begin
            if (v5) begin
                if (q5.size() == 0) begin
                    chk("w5_unexpected_beat", {27'd0, dn5, o5}, 32'h0);
                end else begin
                    e5 = q5.pop_front();
                    chk("w5_beat", {26'd0, v5, dn5, o5}, {26'd0, 1'b1, e5});
                end
            end else begin
                chk("w5_idle_out", {26'd0, dn5, o5}, 32'h0);
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (v8) begin
                if (q8.size() == 0) begin
                    chk("w8_unexpected_beat", {23'd0, dn8, o8}, 32'h0);
                end else begin
                    e8 = q8.pop_front();
                    chk("w8_beat", {22'd0, v8, dn8, o8}, {22'd0, 1'b1, e8});
                end
            end else begin
                chk("w8_idle_out", {23'd0, dn8, o8}, 32'h0);
            end
        end
    end

    task automatic op5(input logic md, input logic [4:0] a, b,
                       input logic [4:0] hi, lo);
        q5.push_back({1'b0, hi});
        q5.push_back({1'b1, lo});
        s5  = 1'b1;
        sm5 = md;
        @(posedge clk); #1;
        s5  = 1'b0;
        sm5 = ~md;
        d5  = a;
        @(posedge clk); #1;
        d5 = b;
        @(posedge clk); #1;
        d5 = 5'($urandom);
        repeat (8) @(posedge clk);
        #1;
        chk("w5_idle_after_op", {31'd0, b5}, 32'd0);
    endtask

    task automatic op8(input logic md, input logic [7:0] a, b,
                       input logic [7:0] hi, lo);
        q8.push_back({1'b0, hi});
        q8.push_back({1'b1, lo});
        s8  = 1'b1;
        sm8 = md;
        @(posedge clk); #1;
        s8  = 1'b0;
        sm8 = ~md;
        d8  = a;
        @(posedge clk); #1;
        d8 = b;
        @(posedge clk); #1;
        d8 = 8'($urandom);
        repeat (11) @(posedge clk);
        #1;
        chk("w8_idle_after_op", {31'd0, b8}, 32'd0);
    endtask

    initial begin
        logic [7:0]  ra, rb;
        logic        rm;
        int          pa, pb, pr;
        logic [15:0] p16;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_w5", {24'd0, b5, v5, dn5, o5}, 32'd0);
        chk("reset_w8", {21'd0, b8, v8, dn8, o8}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // -3 x 7 with explicit beat timing
        q5.push_back({1'b0, 5'h1F});
        q5.push_back({1'b1, 5'h0B});
        s5  = 1'b1;
        sm5 = 1'b1;
        @(posedge clk); #1;
        s5  = 1'b0;
        sm5 = 1'b0;
        d5  = 5'h1D;
        chk("busy_rise", {31'd0, b5}, 32'd1);
        @(posedge clk); #1;
        d5 = 5'd7;
        @(posedge clk); #1;
        d5 = 5'd0;
        repeat (6) @(posedge clk);
        #1;
        chk("hi_beat_timing", {30'd0, v5, dn5}, 32'b10);
        @(posedge clk); #1;
        chk("done_timing", {30'd0, v5, dn5}, 32'b11);
        @(posedge clk); #1;
        chk("idle_timing", {30'd0, v5, b5}, 32'b00);

        op5(1'b0, 5'd31, 5'd31, 5'h1E, 5'h01);
        op5(1'b1, 5'd31, 5'd31, 5'h00, 5'h01);
        op5(1'b1, 5'h10, 5'h10, 5'h08, 5'h00);
        op5(1'b0, 5'd0,  5'd19, 5'h00, 5'h00);

        // start pulse during CALC must not disturb or restart
        q5.push_back({1'b0, 5'h1F});
        q5.push_back({1'b1, 5'h0B});
        s5  = 1'b1;
        sm5 = 1'b1;
        @(posedge clk); #1;
        s5 = 1'b0;
        d5 = 5'h1D;
        @(posedge clk); #1;
        d5 = 5'd7;
        @(posedge clk); #1;
        repeat (2) @(posedge clk);
        #1;
        s5  = 1'b1;
        sm5 = 1'b0;
        d5  = 5'd9;
        @(posedge clk); #1;
        s5 = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("no_restart", {31'd0, b5}, 32'd0);
        chk("calc_start_drained", q5.size(), 32'd0);

        // start held high across the return to IDLE
        q5.push_back({1'b0, 5'h1E});
        q5.push_back({1'b1, 5'h01});
        q5.push_back({1'b0, 5'h1F});
        q5.push_back({1'b1, 5'h02});
        s5  = 1'b1;
        sm5 = 1'b0;
        @(posedge clk); #1;
        d5 = 5'd31;
        @(posedge clk); #1;
        d5 = 5'd31;
        @(posedge clk); #1;
        sm5 = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("held_start_idle", {31'd0, b5}, 32'd0);
        @(posedge clk); #1;
        chk("held_start_restart", {31'd0, b5}, 32'd1);
        s5 = 1'b0;
        d5 = 5'd5;
        @(posedge clk); #1;
        d5 = 5'h1A;
        @(posedge clk); #1;
        repeat (8) @(posedge clk);
        #1;
        chk("held_start_drained", q5.size(), 32'd0);

        // asynchronous reset in the third CALC cycle
        s5  = 1'b1;
        sm5 = 1'b0;
        @(posedge clk); #1;
        s5 = 1'b0;
        d5 = 5'd31;
        @(posedge clk); #1;
        d5 = 5'd31;
        repeat (3) @(posedge clk);
        #1;
        chk("busy_before_rst", {31'd0, b5}, 32'd1);
        rst = 1'b0;
        #1;
        chk("async_rst_outs", {24'd0, b5, v5, dn5, o5}, 32'd0);
        repeat (12) @(posedge clk);
        #1;
        chk("rst_held_outs", {24'd0, b5, v5, dn5, o5}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        op5(1'b1, 5'd5, 5'h1A, 5'h1F, 5'h02);

        op8(1'b1, 8'h80, 8'h7F, 8'hC0, 8'h80);
        op8(1'b0, 8'hFF, 8'hFF, 8'hFE, 8'h01);

        for (int i = 0; i < 500; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rm = 1'($urandom);
            pa = rm ? int'($signed(ra)) : int'(ra);
            pb = rm ? int'($signed(rb)) : int'(rb);
            pr = pa * pb;
            p16 = pr[15:0];
            op8(rm, ra, rb, p16[15:8], p16[7:0]);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("w5_queue_empty", q5.size(), 32'd0);
        chk("w8_queue_empty", q8.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
